load_writeback_unit: RTL and testbench
======================================

LOAD_WRITEBACK_UNIT -- requirements
Module: load_writeback_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width in bits.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5: destination register index width.
REQ-003 SHALL have ports clk (in, 1): clock; reset (in, 1): reset, synchronous, active-high.
REQ-004 SHALL have in_valid (in, 1) and in_ready (out, 1): upstream handshake; transfer when both are high at a clk edge.
REQ-005 SHALL have in_is_load (in, 1), in_funct3 (in, 3), in_addr (in, XLEN), in_alu_result (in, XLEN), in_rd (in, REG_ADDR_WIDTH), in_reg_write (in, 1): instruction payload.
REQ-006 SHALL have mem_req_valid (out, 1), mem_req_ready (in, 1), mem_req_addr (out, XLEN): data-memory read request, always word-aligned.
REQ-007 SHALL have mem_resp_valid (in, 1), mem_resp_data (in, XLEN): read response.
REQ-008 SHALL have rf_write_enable (out, 1), rf_write_width (out, 4), rf_write_reg_addr (out, REG_ADDR_WIDTH), rf_write_data (out, XLEN): register-file write port.
REQ-009 SHALL have load_misaligned (out, 1): one-cycle fault pulse; busy (out, 1): high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT, WB.
REQ-011 SHALL drive in_ready high only in IDLE and WB.
REQ-012 On a non-load transfer: SHALL go to WB and capture in_alu_result, in_rd and in_reg_write.
REQ-013 On an aligned load transfer: SHALL go to REQ and capture the payload.
REQ-014 In REQ: SHALL hold mem_req_valid high with stable mem_req_addr = {addr[XLEN-1:2], 2'b00}; on mem_req_ready, SHALL go to WAIT.
REQ-015 In WAIT: on mem_resp_valid, SHALL capture the aligned and extended data and go to WB; other cycles SHALL hold.
REQ-016 In WB: SHALL assert rf_write_enable for exactly one cycle when reg_write=1 and rd!=0; rd=0 SHALL never write.
REQ-017 In WB: a simultaneous new transfer SHALL be accepted (back-to-back); otherwise the FSM SHALL return to IDLE.
REQ-018 Non-load write latency SHALL be 1 cycle after the transfer edge.
REQ-019 Load write latency SHALL be 1 cycle after the mem_resp_valid edge.
REQ-020 Load extraction: byte lane = addr[1:0]; half lane = addr[1].
REQ-021 LB/LH SHALL sign-extend to XLEN with rf_write_width=4.
REQ-022 LBU SHALL drive rf_write_width=1 and LHU rf_write_width=2, with data zero-filled above the field.
REQ-023 LW and non-load writes SHALL drive rf_write_width=4.
REQ-024 Undefined load funct3 (3, 6, 7): SHALL complete with no register write.
REQ-025 mem_resp_valid outside WAIT SHALL be ignored.
REQ-026 Outside WB: rf_write_enable SHALL be 0, and rf_write_width, rf_write_reg_addr and rf_write_data SHALL hold their last values.

Reset
REQ-027 Reset SHALL force IDLE from any state, including REQ and WAIT.
REQ-028 Reset SHALL clear all outputs and captured registers to 0, with in_ready=1 in the first cycle after reset.
REQ-029 A memory response arriving after a mid-operation reset SHALL be discarded.

Configuration
REQ-030 With LOAD_WRITEBACK_MISALIGN_TRAP_EN defined: a load with LH/LHU and addr[0]=1, or LW and addr[1:0]!=0, SHALL issue no memory request and no write, and SHALL pulse load_misaligned for the cycle after transfer while the FSM stays in IDLE.
REQ-031 Without LOAD_WRITEBACK_MISALIGN_TRAP_EN: load_misaligned SHALL be tied 0, and misaligned loads SHALL proceed with the offending low address bits forced to 0.

Structure
REQ-032 Funct3 load codes, write-width constants (1, 2, 4) and the FSM state encoding SHALL live in shared package hubris_pkg.
REQ-033 Lane selection and extension SHALL be a combinational sub-module load_align_extend.

Verification
REQ-034 ADD result 0x1234 to rd=5 -> one cycle later: rf_write_enable=1, addr=5, width=4, data=0x00001234.
REQ-035 LB addr=0x103, mem_resp_data=0x80FFFFFF, mem_req_ready delayed 3 cycles -> mem_req_addr=0x100 held for 3 cycles; then write data=0xFFFFFF80, width=4.
REQ-036 LHU addr=0x202, mem_resp_data=0xBEEF0000 -> write data=0x0000BEEF, width=2.
REQ-037 LW to rd=0 -> full memory handshake occurs, rf_write_enable stays 0.
REQ-038 Reset asserted in WAIT, then mem_resp_valid -> no write, in_ready=1, busy=0.
REQ-039 LW addr=0x101 with macro defined -> load_misaligned=1 for one cycle, no mem_req_valid; without macro -> mem_req_addr=0x100 and normal write.

Source files
------------

// File: rtl/hubris_pkg.sv
// Shared load/writeback constants: funct3 load codes,
// register-file write widths and the writeback FSM encoding.
package hubris_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   localparam logic [3:0] WIDTH_B = 4'd1;
   localparam logic [3:0] WIDTH_H = 4'd2;
   localparam logic [3:0] WIDTH_W = 4'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_WB   = 2'd3
   } lwb_state_e;

endpackage

// File: rtl/load_align_extend.sv
// Picks the byte/half lane from a memory word and sign- or zero-extends it.
// ok_o is low for funct3 codes that are not defined loads.
module load_align_extend
   import hubris_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      lane_i,
   input  logic [XLEN-1:0] data_i,
   output logic [XLEN-1:0] data_o,
   output logic [3:0]      width_o,
   output logic            ok_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = data_i[8*int'(lane_i) +: 8];
      half_v = data_i[16*int'(lane_i[1]) +: 16];
   end

   always_comb begin
      data_o  = data_i;
      width_o = WIDTH_W;
      ok_o    = 1'b1;
      unique case (funct3_i)
         F3_LB:  data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
         F3_LH:  data_o = {{(XLEN-16){half_v[15]}}, half_v};
         F3_LW:  data_o = data_i;
         F3_LBU: begin
            data_o  = {{(XLEN-8){1'b0}}, byte_v};
            width_o = WIDTH_B;
         end
         F3_LHU: begin
            data_o  = {{(XLEN-16){1'b0}}, half_v};
            width_o = WIDTH_H;
         end
         default: ok_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/load_writeback_unit.sv
// Load/writeback stage: word-aligned memory read, lane extraction, RF write.
// LOAD_WRITEBACK_MISALIGN_TRAP_EN: trap misaligned LH/LHU/LW instead of masking.
module load_writeback_unit
   import hubris_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_is_load,
   input  logic [2:0]                in_funct3,
   input  logic [XLEN-1:0]           in_addr,
   input  logic [XLEN-1:0]           in_alu_result,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd,
   input  logic                      in_reg_write,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [XLEN-1:0]           mem_req_addr,
   input  logic                      mem_resp_valid,
   input  logic [XLEN-1:0]           mem_resp_data,
   output logic                      rf_write_enable,
   output logic [3:0]                rf_write_width,
   output logic [REG_ADDR_WIDTH-1:0] rf_write_reg_addr,
   output logic [XLEN-1:0]           rf_write_data,
   output logic                      load_misaligned,
   output logic                      busy
);

   lwb_state_e                state_q, state_d;
   logic [2:0]                f3_q, f3_d;
   logic [XLEN-1:0]           addr_q, addr_d;
   logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
   logic                      rw_q, rw_d;
   logic                      we_q, we_d;
   logic [3:0]                width_q, width_d;
   logic [REG_ADDR_WIDTH-1:0] wreg_q, wreg_d;
   logic [XLEN-1:0]           wdata_q, wdata_d;
`ifdef LOAD_WRITEBACK_MISALIGN_TRAP_EN
   logic                      mis_q, mis_d;
`endif

   logic            accept;
   logic [1:0]      fix_mask;
   logic [XLEN-1:0] ext_data;
   logic [3:0]      ext_width;
   logic            ext_ok;

   load_align_extend #(.XLEN(XLEN)) u_align (
      .funct3_i (f3_q),
      .lane_i   (addr_q[1:0]),
      .data_i   (mem_resp_data),
      .data_o   (ext_data),
      .width_o  (ext_width),
      .ok_o     (ext_ok)
   );

   // Low address bits that must be zero for the requested access size
   always_comb begin
      fix_mask = 2'b00;
      if (in_funct3 == F3_LH || in_funct3 == F3_LHU) fix_mask = 2'b01;
      if (in_funct3 == F3_LW) fix_mask = 2'b11;
   end

   assign in_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      rw_d    = rw_q;
      we_d    = 1'b0;
      width_d = width_q;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
`ifdef LOAD_WRITEBACK_MISALIGN_TRAP_EN
      mis_d   = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE, ST_WB: begin
            state_d = ST_IDLE;
            if (accept && !in_is_load) begin
               state_d = ST_WB;
               rd_d    = in_rd;
               rw_d    = in_reg_write;
               we_d    = in_reg_write && (in_rd != '0);
               width_d = WIDTH_W;
               wreg_d  = in_rd;
               wdata_d = in_alu_result;
            end else if (accept) begin
`ifdef LOAD_WRITEBACK_MISALIGN_TRAP_EN
               if ((in_addr[1:0] & fix_mask) != 2'b00) begin
                  mis_d = 1'b1;
               end else begin
                  state_d = ST_REQ;
                  f3_d    = in_funct3;
                  addr_d  = in_addr;
                  rd_d    = in_rd;
                  rw_d    = in_reg_write;
               end
`else
               state_d = ST_REQ;
               f3_d    = in_funct3;
               addr_d  = {in_addr[XLEN-1:2], in_addr[1:0] & ~fix_mask};
               rd_d    = in_rd;
               rw_d    = in_reg_write;
`endif
            end
         end
         ST_REQ: begin
            if (mem_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               state_d = ST_WB;
               we_d    = rw_q && (rd_q != '0) && ext_ok;
               width_d = ext_width;
               wreg_d  = rd_q;
               wdata_d = ext_data;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         f3_q    <= '0;
         addr_q  <= '0;
         rd_q    <= '0;
         rw_q    <= 1'b0;
         we_q    <= 1'b0;
         width_q <= '0;
         wreg_q  <= '0;
         wdata_q <= '0;
`ifdef LOAD_WRITEBACK_MISALIGN_TRAP_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         rw_q    <= rw_d;
         we_q    <= we_d;
         width_q <= width_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
`ifdef LOAD_WRITEBACK_MISALIGN_TRAP_EN
         mis_q   <= mis_d;
`endif
      end
   end

   assign mem_req_valid     = (state_q == ST_REQ);
   assign mem_req_addr      = {addr_q[XLEN-1:2], 2'b00};
   assign rf_write_enable   = we_q;
   assign rf_write_width    = width_q;
   assign rf_write_reg_addr = wreg_q;
   assign rf_write_data     = wdata_q;
   assign busy              = (state_q != ST_IDLE);
`ifdef LOAD_WRITEBACK_MISALIGN_TRAP_EN
   assign load_misaligned   = mis_q;
`else
   assign load_misaligned   = 1'b0;
`endif

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit: ALU writes, loads, reset, misalign.
module tb_load_writeback_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_is_load;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr;
   logic [31:0] in_alu_result;
   logic [4:0]  in_rd;
   logic        in_reg_write;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        rf_write_enable;
   logic [3:0]  rf_write_width;
   logic [4:0]  rf_write_reg_addr;
   logic [31:0] rf_write_data;
   logic        load_misaligned;
   logic        busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   load_writeback_unit dut (
      .clk               (clk),
      .reset             (reset),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_is_load        (in_is_load),
      .in_funct3         (in_funct3),
      .in_addr           (in_addr),
      .in_alu_result     (in_alu_result),
      .in_rd             (in_rd),
      .in_reg_write      (in_reg_write),
      .mem_req_valid     (mem_req_valid),
      .mem_req_ready     (mem_req_ready),
      .mem_req_addr      (mem_req_addr),
      .mem_resp_valid    (mem_resp_valid),
      .mem_resp_data     (mem_resp_data),
      .rf_write_enable   (rf_write_enable),
      .rf_write_width    (rf_write_width),
      .rf_write_reg_addr (rf_write_reg_addr),
      .rf_write_data     (rf_write_data),
      .load_misaligned   (load_misaligned),
      .busy              (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic ld, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] alu,
                       input logic [4:0] rd);
      in_valid      = 1'b1;
      in_is_load    = ld;
      in_funct3     = f3;
      in_addr       = a;
      in_alu_result = alu;
      in_rd         = rd;
      in_reg_write  = 1'b1;
   endtask

   // Full load with an immediately ready memory; leaves time just after the
   // write-back edge so the caller can inspect the RF port.
   task automatic do_load(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [4:0] rd,
                          input logic [31:0] resp, input logic [31:0] exp_req);
      int n;
      send(1'b1, f3, a, 32'h0, rd);
      step();
      in_valid = 1'b0;
      n = 0;
      while (!mem_req_valid && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_req_seen"}, 32'(mem_req_valid), 32'd1);
      chk({tag, "_req_addr"}, mem_req_addr, exp_req);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = resp;
      step();
      mem_resp_valid = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      in_valid       = 1'b0;
      in_is_load     = 1'b0;
      in_funct3      = 3'd0;
      in_addr        = 32'h0;
      in_alu_result  = 32'h0;
      in_rd          = 5'd0;
      in_reg_write   = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      step();
      step();
      reset = 1'b0;

      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_we", 32'(rf_write_enable), 32'd0);
      chk("rst_data", rf_write_data, 32'h0);
      chk("rst_width", 32'(rf_write_width), 32'd0);
      chk("rst_req", 32'(mem_req_valid), 32'd0);
      chk("rst_mis", 32'(load_misaligned), 32'd0);

      // ADD result to x5
      send(1'b0, 3'd0, 32'h0, 32'h1234, 5'd5);
      step();
      in_valid = 1'b0;
      chk("add_we", 32'(rf_write_enable), 32'd1);
      chk("add_rd", 32'(rf_write_reg_addr), 32'd5);
      chk("add_width", 32'(rf_write_width), 32'd4);
      chk("add_data", rf_write_data, 32'h0000_1234);
      step();
      chk("add_we_off", 32'(rf_write_enable), 32'd0);
      chk("add_hold", rf_write_data, 32'h0000_1234);
      chk("add_idle", 32'(busy), 32'd0);

      // LB with memory ready delayed by 3 cycles
      send(1'b1, 3'd0, 32'h103, 32'h0, 5'd7);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("lb_req_valid", 32'(mem_req_valid), 32'd1);
         chk("lb_req_addr", mem_req_addr, 32'h100);
         chk("lb_in_ready", 32'(in_ready), 32'd0);
         if (i < 2) step();
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("lb_wait_req", 32'(mem_req_valid), 32'd0);
      chk("lb_wait_we", 32'(rf_write_enable), 32'd0);
      step();
      chk("lb_wait_hold", 32'(busy), 32'd1);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h80FF_FFFF;
      step();
      mem_resp_valid = 1'b0;
      chk("lb_we", 32'(rf_write_enable), 32'd1);
      chk("lb_rd", 32'(rf_write_reg_addr), 32'd7);
      chk("lb_data", rf_write_data, 32'hFFFF_FF80);
      chk("lb_width", 32'(rf_write_width), 32'd4);
      step();
      chk("lb_we_off", 32'(rf_write_enable), 32'd0);

      do_load("lhu", 3'd5, 32'h202, 5'd3, 32'hBEEF_0000, 32'h200);
      chk("lhu_we", 32'(rf_write_enable), 32'd1);
      chk("lhu_data", rf_write_data, 32'h0000_BEEF);
      chk("lhu_width", 32'(rf_write_width), 32'd2);
      step();

      do_load("lh", 3'd1, 32'h102, 5'd4, 32'h8001_1234, 32'h100);
      chk("lh_data", rf_write_data, 32'hFFFF_8001);
      chk("lh_width", 32'(rf_write_width), 32'd4);
      step();

      do_load("lbu", 3'd4, 32'h101, 5'd6, 32'h0000_A500, 32'h100);
      chk("lbu_data", rf_write_data, 32'h0000_00A5);
      chk("lbu_width", 32'(rf_write_width), 32'd1);
      step();

      do_load("lw_x0", 3'd2, 32'h300, 5'd0, 32'h1111_2222, 32'h300);
      chk("lw_x0_we", 32'(rf_write_enable), 32'd0);
      step();

      do_load("f3_6", 3'd6, 32'h300, 5'd9, 32'h3333_4444, 32'h300);
      chk("f3_6_we", 32'(rf_write_enable), 32'd0);
      step();
      chk("f3_6_idle", 32'(busy), 32'd0);

      // Response while idle is ignored
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h5555_5555;
      step();
      mem_resp_valid = 1'b0;
      chk("stray_we", 32'(rf_write_enable), 32'd0);
      chk("stray_busy", 32'(busy), 32'd0);

      // Back-to-back ALU writes through WB
      send(1'b0, 3'd0, 32'h0, 32'h11, 5'd1);
      step();
      chk("b2b_we1", 32'(rf_write_enable), 32'd1);
      chk("b2b_ready", 32'(in_ready), 32'd1);
      send(1'b0, 3'd0, 32'h0, 32'h22, 5'd2);
      step();
      in_valid = 1'b0;
      chk("b2b_we2", 32'(rf_write_enable), 32'd1);
      chk("b2b_rd2", 32'(rf_write_reg_addr), 32'd2);
      chk("b2b_data2", rf_write_data, 32'h22);
      step();
      chk("b2b_off", 32'(rf_write_enable), 32'd0);

      // Reset while waiting for a response
      send(1'b1, 3'd2, 32'h400, 32'h0, 5'd8);
      step();
      in_valid      = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("rw_in_wait", 32'(in_ready), 32'd0);
      reset = 1'b1;
      step();
      reset          = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h6666_7777;
      step();
      mem_resp_valid = 1'b0;
      chk("rw_we", 32'(rf_write_enable), 32'd0);
      chk("rw_in_ready", 32'(in_ready), 32'd1);
      chk("rw_busy", 32'(busy), 32'd0);
      chk("rw_data", rf_write_data, 32'h0);
      step();
      chk("rw_we2", 32'(rf_write_enable), 32'd0);

      // Misaligned LW
`ifdef LOAD_WRITEBACK_MISALIGN_TRAP_EN
      send(1'b1, 3'd2, 32'h101, 32'h0, 5'd10);
      step();
      in_valid = 1'b0;
      chk("mis_pulse", 32'(load_misaligned), 32'd1);
      chk("mis_req", 32'(mem_req_valid), 32'd0);
      chk("mis_busy", 32'(busy), 32'd0);
      chk("mis_we", 32'(rf_write_enable), 32'd0);
      step();
      chk("mis_pulse_off", 32'(load_misaligned), 32'd0);
      chk("mis_req2", 32'(mem_req_valid), 32'd0);
`else
      do_load("mis", 3'd2, 32'h101, 5'd10, 32'hCAFE_BABE, 32'h100);
      chk("mis_flag", 32'(load_misaligned), 32'd0);
      chk("mis_we", 32'(rf_write_enable), 32'd1);
      chk("mis_data", rf_write_data, 32'hCAFE_BABE);
      chk("mis_width", 32'(rf_write_width), 32'd4);
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
